// File: rtl/misr_sig_ctrl.sv
// MISR signature controller: memory-mapped register bank plus START/RUN/DONE
// capture sequencer folding a qualified sample stream into a signature register.
module misr_sig_ctrl #(
   parameter int unsigned          NBIT_DATA              = 32,
   parameter int unsigned          NBIT_ADDR              = 32,
   parameter logic [NBIT_ADDR-1:0] MISR_PERIPH_START_ADDR = NBIT_ADDR'(2**25),
   parameter logic [NBIT_DATA-1:0] MISR_POLY              = NBIT_DATA'(32'h04C1_1DB7)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 re_i,
   input  logic                 we_i,
   input  logic [NBIT_ADDR-1:0] addr_i,
   input  logic [NBIT_DATA-1:0] wdata_i,
   output logic [NBIT_DATA-1:0] rdata_o,
   output logic                 rvalid_o,
   input  logic                 sample_valid_i,
   input  logic [NBIT_DATA-1:0] sample_data_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 irq_o
);

   localparam logic [4:0] OffCtrl   = 5'h00;
   localparam logic [4:0] OffStatus = 5'h04;
   localparam logic [4:0] OffSeed   = 5'h08;
   localparam logic [4:0] OffLen    = 5'h0C;
   localparam logic [4:0] OffSig    = 5'h10;
   localparam logic [4:0] OffCnt    = 5'h14;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [NBIT_DATA-1:0] seed_q, seed_d;
   logic [NBIT_DATA-1:0] len_q, len_d;
   logic [NBIT_DATA-1:0] sig_q, sig_d;
   logic [NBIT_DATA-1:0] cnt_q, cnt_d;
   logic [NBIT_DATA-1:0] rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 irq_q, irq_d;

   logic [NBIT_ADDR-1:0] offset;
   logic                 mapped;
   logic                 wr_en;
   logic                 rd_en;
   logic                 start;
   logic                 clear;
   logic                 last_sample;
   logic [NBIT_DATA-1:0] sig_upd;

   assign offset      = addr_i - MISR_PERIPH_START_ADDR;
   assign mapped      = (offset[NBIT_ADDR-1:5] == '0);
   assign wr_en       = we_i && mapped;
   // A simultaneous write suppresses the read entirely, mapped or not.
   assign rd_en       = re_i && !we_i;
   assign start       = wr_en && (offset[4:0] == OffCtrl) && wdata_i[0];
   assign clear       = wr_en && (offset[4:0] == OffCtrl) && wdata_i[1];
   assign last_sample = (cnt_q == (len_q - NBIT_DATA'(1)));
   assign sig_upd     = {sig_q[NBIT_DATA-2:0], 1'b0}
                        ^ (sig_q[NBIT_DATA-1] ? MISR_POLY : '0)
                        ^ sample_data_i;

   // Read path samples pre-update register values.
   always_comb begin
      rdata_d  = '0;
      rvalid_d = rd_en;
      if (rd_en && mapped) begin
         case (offset[4:0])
            OffStatus: rdata_d = {{(NBIT_DATA-2){1'b0}}, done_q, busy_q};
            OffSeed:   rdata_d = seed_q;
            OffLen:    rdata_d = len_q;
            OffSig:    rdata_d = sig_q;
            OffCnt:    rdata_d = cnt_q;
            default:   rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      seed_d  = seed_q;
      len_d   = len_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      irq_d   = 1'b0;

      if (wr_en && (state_q != StRun)) begin
         case (offset[4:0])
            OffSeed: seed_d = wdata_i;
            OffLen:  len_d  = wdata_i;
            default: ;
         endcase
      end

      if (clear) begin
         state_d = StIdle;
         sig_d   = '0;
         cnt_d   = '0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  sig_d = seed_q;
                  cnt_d = '0;
                  if (len_q == '0) begin
                     state_d = StDone;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     irq_d   = 1'b1;
                  end else begin
                     state_d = StRun;
                     busy_d  = 1'b1;
                     done_d  = 1'b0;
                  end
               end
            end
            StRun: begin
               if (sample_valid_i) begin
                  sig_d = sig_upd;
                  cnt_d = cnt_q + NBIT_DATA'(1);
                  if (last_sample) begin
                     state_d = StDone;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     irq_d   = 1'b1;
                  end
               end
            end
            default: begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         seed_q   <= '0;
         len_q    <= '0;
         sig_q    <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         len_q    <= len_d;
         sig_q    <= sig_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         irq_q    <= irq_d;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_misr_sig_ctrl.sv
// Bench for misr_sig_ctrl: register-table vectors plus capture-sequence checks,
// with read responses matched against a queue of expected values.
module tb_misr_sig_ctrl;

   localparam logic [31:0] Base = 32'h0200_0000;
   localparam logic [31:0] Poly = 32'h04C1_1DB7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        re;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        svalid;
   logic [31:0] sdata;
   logic        busy;
   logic        done;
   logic        irq;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] data;
      int          due;
      string       name;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        we;
      logic [31:0] off;
      logic [31:0] data;
      string       name;
   } vec_t;
   vec_t tbl[$];

   misr_sig_ctrl dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .re_i           (re),
      .we_i           (we),
      .addr_i         (addr),
      .wdata_i        (wdata),
      .rdata_o        (rdata),
      .rvalid_o       (rvalid),
      .sample_valid_i (svalid),
      .sample_data_i  (sdata),
      .busy_o         (busy),
      .done_o         (done),
      .irq_o          (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
      return {s[30:0], 1'b0} ^ (s[31] ? Poly : 32'h0) ^ d;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] data);
      addr  = Base + off;
      wdata = data;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string name);
      exp_t e;
      addr   = Base + off;
      re     = 1'b1;
      e.data = exp;
      e.due  = cyc + 1;
      e.name = name;
      sb.push_back(e);
      tick();
      re = 1'b0;
   endtask

   // Response monitor, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (rvalid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_rvalid: got rvalid=1 rdata=%h expected no response", rdata);
         end else begin
            e = sb.pop_front();
            chk(e.name, rdata, e.data);
            chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
         end
      end else begin
         if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s_missing: got rvalid=0 expected rvalid=1 data %h", e.name, e.data);
         end
         chk("rdata_idle_zero", rdata, 32'h0);
      end
   end

   initial begin
      logic [31:0] exp_sig;
      logic [31:0] d [5];
      logic        v [5];
      int          nvalid;

      rst_n  = 1'b0;
      re     = 1'b0;
      we     = 1'b0;
      addr   = Base;
      wdata  = '0;
      svalid = 1'b0;
      sdata  = '0;
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      rst_n = 1'b1;
      tick();

      // Register-map vectors
      tbl.push_back('{1'b0, 32'h00, 32'h0, "rst_rd_ctrl"});
      tbl.push_back('{1'b0, 32'h04, 32'h0, "rst_rd_status"});
      tbl.push_back('{1'b0, 32'h08, 32'h0, "rst_rd_seed"});
      tbl.push_back('{1'b0, 32'h0C, 32'h0, "rst_rd_len"});
      tbl.push_back('{1'b0, 32'h10, 32'h0, "rst_rd_sig"});
      tbl.push_back('{1'b0, 32'h14, 32'h0, "rst_rd_cnt"});
      tbl.push_back('{1'b0, 32'h40, 32'h0, "rd_unmapped"});
      tbl.push_back('{1'b1, 32'h08, 32'h1234_5678, ""});
      tbl.push_back('{1'b0, 32'h08, 32'h1234_5678, "rd_seed_wr"});
      tbl.push_back('{1'b1, 32'h0C, 32'h0000_0005, ""});
      tbl.push_back('{1'b0, 32'h0C, 32'h0000_0005, "rd_len_wr"});
      tbl.push_back('{1'b1, 32'h10, 32'hFFFF_FFFF, ""});
      tbl.push_back('{1'b0, 32'h10, 32'h0, "rd_sig_ro"});
      tbl.push_back('{1'b1, 32'h14, 32'hFFFF_FFFF, ""});
      tbl.push_back('{1'b0, 32'h14, 32'h0, "rd_cnt_ro"});
      tbl.push_back('{1'b1, 32'h48, 32'hDEAD_BEEF, ""});
      tbl.push_back('{1'b0, 32'h08, 32'h1234_5678, "rd_seed_after_unmapped_wr"});
      tbl.push_back('{1'b0, 32'h00, 32'h0, "rd_ctrl_zero"});
      foreach (tbl[i]) begin
         if (tbl[i].we) wr(tbl[i].off, tbl[i].data);
         else rd(tbl[i].off, tbl[i].data, tbl[i].name);
      end
      tick();

      // LEN=1, sample 1
      wr(32'h08, 32'h0);
      wr(32'h0C, 32'h1);
      wr(32'h00, 32'h1);
      chk("t2_busy_run", 32'(busy), 1);
      svalid = 1'b1;
      sdata  = 32'h1;
      tick();
      svalid = 1'b0;
      chk("t2_done", 32'(done), 1);
      chk("t2_irq", 32'(irq), 1);
      chk("t2_busy_low", 32'(busy), 0);
      tick();
      chk("t2_irq_pulse", 32'(irq), 0);
      chk("t2_done_sticky", 32'(done), 1);
      rd(32'h10, 32'h1, "t2_sig");
      rd(32'h14, 32'h1, "t2_cnt");
      rd(32'h04, 32'h2, "t2_status");

      // Poly feedback; samples outside RUN ignored
      wr(32'h08, 32'h8000_0000);
      svalid = 1'b1;
      sdata  = 32'hFFFF_0000;
      tick();
      svalid = 1'b0;
      rd(32'h10, 32'h1, "t3_sig_pre_start");
      wr(32'h00, 32'h1);
      chk("t3_done_cleared", 32'(done), 0);
      svalid = 1'b1;
      sdata  = 32'h0;
      tick();
      chk("t3_done", 32'(done), 1);
      sdata = 32'h5555_AAAA;
      tick();
      svalid = 1'b0;
      rd(32'h10, 32'h04C1_1DB7, "t3_sig");

      // LEN=3, gapped samples, protected SEED/LEN during RUN
      wr(32'h08, 32'h0000_1111);
      wr(32'h0C, 32'h3);
      wr(32'h00, 32'h1);
      wr(32'h08, 32'hDEAD_0000);
      wr(32'h0C, 32'h9);
      d = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'h8765_4321, 32'h0F0F_F0F0};
      v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_sig = 32'h0000_1111;
      nvalid  = 0;
      for (int i = 0; i < 5; i++) begin
         exp_t e;
         svalid = v[i];
         sdata  = d[i];
         if (i == 3) begin
            addr   = Base + 32'h14;
            re     = 1'b1;
            e.data = 32'h1;
            e.due  = cyc + 1;
            e.name = "t4_cnt_pre_update";
            sb.push_back(e);
         end
         if (v[i]) begin
            exp_sig = misr_step(exp_sig, d[i]);
            nvalid++;
         end
         tick();
         re = 1'b0;
         chk($sformatf("t4_done_%0d", i), 32'(done), (nvalid == 3) ? 32'h1 : 32'h0);
         chk($sformatf("t4_busy_%0d", i), 32'(busy), (nvalid == 3) ? 32'h0 : 32'h1);
      end
      svalid = 1'b0;
      rd(32'h10, exp_sig, "t4_sig");
      rd(32'h14, 32'h3, "t4_cnt");
      rd(32'h08, 32'h0000_1111, "t4_seed_kept");
      rd(32'h0C, 32'h3, "t4_len_kept");

      // LEN=0 goes straight to DONE; START|CLEAR clears
      wr(32'h08, 32'h0BAD_F00D);
      wr(32'h0C, 32'h0);
      wr(32'h00, 32'h1);
      chk("t5_done", 32'(done), 1);
      chk("t5_irq", 32'(irq), 1);
      chk("t5_busy", 32'(busy), 0);
      rd(32'h10, 32'h0BAD_F00D, "t5_sig_seed");
      wr(32'h00, 32'h3);
      chk("t5_clear_done", 32'(done), 0);
      chk("t5_clear_busy", 32'(busy), 0);
      rd(32'h10, 32'h0, "t5_sig_clear");
      rd(32'h14, 32'h0, "t5_cnt_clear");
      rd(32'h08, 32'h0BAD_F00D, "t5_seed_kept");

      // Simultaneous read and write
      addr  = Base + 32'h08;
      wdata = 32'hA5A5_A5A5;
      re    = 1'b1;
      we    = 1'b1;
      tick();
      re = 1'b0;
      we = 1'b0;
      chk("t6_no_rvalid", 32'(rvalid), 0);
      rd(32'h08, 32'hA5A5_A5A5, "t6_seed");

      // Reset mid-RUN
      wr(32'h0C, 32'h5);
      wr(32'h00, 32'h1);
      svalid = 1'b1;
      sdata  = 32'h1234;
      tick();
      svalid = 1'b0;
      chk("t7_busy_before", 32'(busy), 1);
      rst_n = 1'b0;
      tick();
      chk("t7_rst_busy", 32'(busy), 0);
      chk("t7_rst_done", 32'(done), 0);
      chk("t7_rst_irq", 32'(irq), 0);
      chk("t7_rst_rvalid", 32'(rvalid), 0);
      rst_n = 1'b1;
      tick();
      chk("t7_irq_after", 32'(irq), 0);
      rd(32'h08, 32'h0, "t7_seed");
      rd(32'h0C, 32'h0, "t7_len");
      rd(32'h10, 32'h0, "t7_sig");
      rd(32'h14, 32'h0, "t7_cnt");

      repeat (3) tick();
      chk("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/misr_sig_ctrl.md
Name: misr_sig_ctrl

Overview:
- Sequencing controller and register bank for the MISR signature peripheral mapped at MISR_PERIPH_START_ADDR and above.
- Takes the MISR-side read/write strobes produced by the address decoder and exposes a small memory-mapped register file (control, status, seed, length, signature, count).
- Runs a START/RUN/DONE capture sequence that folds a qualified sample stream into a multiple-input signature register.
- Raises a one-cycle completion interrupt.

Parameters:
- NBIT_DATA, 32, register, sample and signature width.
- NBIT_ADDR, 32, width of the incoming MISR address.
- MISR_PERIPH_START_ADDR, 2**25, base address of the register map.
- MISR_POLY, 32'h04C11DB7, feedback polynomial; bit i set means XOR feedback into bit i.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset. Synchronous, active-low.
- re_i  input  1  read strobe from the decoder, one cycle per access.
- we_i  input  1  write strobe from the decoder, one cycle per access.
- addr_i  input  NBIT_ADDR  access address. Offset = addr_i - MISR_PERIPH_START_ADDR.
- wdata_i  input  NBIT_DATA  write data.
- rdata_o  output  NBIT_DATA  read data. Valid while rvalid_o=1.
- rvalid_o  output  1  read response pulse.
- sample_valid_i  input  1  sample qualifier.
- sample_data_i  input  NBIT_DATA  sample word folded into the signature.
- busy_o  output  1  FSM in RUN.
- done_o  output  1  sticky completion flag.
- irq_o  output  1  one-cycle pulse on entry to DONE.

Behaviour:
Register map (offset; bits above offset[4:0] must be zero, otherwise unmapped):
- 0x00 CTRL, write-only pulses. bit0 START, bit1 CLEAR. Reads return 0.
- 0x04 STATUS, read-only. bit0 busy, bit1 done.
- 0x08 SEED, read/write.
- 0x0C LEN, read/write. Number of samples to capture.
- 0x10 SIG, read-only. Current signature.
- 0x14 CNT, read-only. Samples captured so far.

Reset (rst_ni=0 sampled at a clk_i edge):
- FSM to IDLE.
- SEED, LEN, SIG, CNT and rdata_o to 0.
- rvalid_o, busy_o, done_o and irq_o to 0.

Register access:
- Read: 1-cycle latency. re_i at edge N gives rvalid_o=1 and rdata_o after edge N+1 for exactly one cycle.
- Unmapped read returns 0 with rvalid_o=1.
- rdata_o returns to 0 when rvalid_o=0.
- Write takes effect at the same edge. Unmapped writes and writes to read-only registers are ignored.
- re_i and we_i together: the write is performed, the read is dropped, and no rvalid_o is produced.
- SEED and LEN writes while in RUN are ignored.

Signature update, applied once per cycle with sample_valid_i=1 in RUN:
- SIG_next = {SIG[NBIT_DATA-2:0],1'b0} ^ (SIG[NBIT_DATA-1] ? MISR_POLY : 0) ^ sample_data_i.
- CNT_next = CNT + 1.
- sample_valid_i is ignored outside RUN.

FSM:
- IDLE: START loads SIG=SEED and CNT=0. If LEN==0, go to DONE. Otherwise go to RUN.
- RUN: busy_o=1. A valid sample with CNT==LEN-1 updates SIG and CNT, then goes to DONE. START is ignored.
- DONE: done_o=1, sticky. irq_o is 1 only in the first cycle after entry. START behaves as from IDLE (reload and rerun). done_o clears on the START edge.
- CLEAR in any state: go to IDLE, SIG=0, CNT=0, done_o=0. SEED and LEN are kept.
- START and CLEAR written together: CLEAR wins.

Other rules:
- A SIG or CNT read in the same cycle as an update returns the pre-update value.
- CNT wraps modulo 2^NBIT_DATA. This is unreachable when LEN is at most 2^NBIT_DATA-1.
- Reset asserted mid-RUN: full reset at the next edge. No irq_o is generated.

Test Plan:
- Reset then read every register at offsets 0x00–0x14 -> each returns 0 with rvalid_o exactly one cycle after re_i. Read at offset 0x40 -> 0, rvalid_o=1.
- SEED=0, LEN=1, START, sample 0x00000001 -> SIG=0x00000001, CNT=1, done_o=1, irq_o single pulse, busy_o low after the transition.
- SEED=0x80000000, LEN=1, START, sample 0x00000000 -> SIG=0x04C11DB7. Samples presented before START and after DONE leave SIG unchanged.
- LEN=3 with sample_valid_i gapped (1,0,0,1,1) -> DONE exactly on the third valid sample, CNT=3. Writes to SEED and LEN during RUN leave their values unchanged.
- LEN=0, START -> DONE the next cycle, SIG=SEED, irq_o pulse. CTRL write 0x3 (START|CLEAR) -> IDLE, SIG=0, done_o=0.
- re_i and we_i together on SEED with 0xA5A5A5A5 -> SEED=0xA5A5A5A5, no rvalid_o. Reset pulse mid-RUN -> all outputs 0, no irq_o.
